// File: rtl/present_inv_key_schedule_if.sv
// Round-key request/delivery bundle between a PRESENT-80 decrypt datapath
// (master) and the inverse key schedule (slave).
interface present_inv_key_schedule_if;
  logic [79:0] key;
  logic        start;
  logic        busy;
  logic        valid;
  logic        next;
  logic [63:0] roundkey;
  logic [4:0]  key_index;
  logic        done;

  modport master (
    output key, start, next,
    input  busy, valid, roundkey, key_index, done
  );

  modport slave (
    input  key, start, next,
    output busy, valid, roundkey, key_index, done
  );
endinterface

// File: rtl/present_inv_key_schedule.sv
// PRESENT-80 decrypt round-key generator: winds the key schedule forward to the
// last round once, then unwinds it one inverse update per consumer request.
module present_inv_key_schedule #(
  parameter int ROUNDS = 32
) (
  input logic                        clk,
  input logic                        rst,
  present_inv_key_schedule_if.slave  bus
);

  localparam logic [4:0] LAST_IDX = 5'(ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_FWD = 2'd1,
    SERVE    = 2'd2,
    DONE     = 2'd3
  } fsm_t;

  fsm_t        fsm_r, fsm_s;
  logic [79:0] state_r, state_s;
  logic [4:0]  idx_r, idx_s;
  logic        busy_r, valid_r, done_r;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  4'hF: sbox = 4'h2;
      default: sbox = 4'h0;
    endcase
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    case (x)
      4'h0: sbox_inv = 4'h5;  4'h1: sbox_inv = 4'hE;  4'h2: sbox_inv = 4'hF;  4'h3: sbox_inv = 4'h8;
      4'h4: sbox_inv = 4'hC;  4'h5: sbox_inv = 4'h1;  4'h6: sbox_inv = 4'h2;  4'h7: sbox_inv = 4'hD;
      4'h8: sbox_inv = 4'hB;  4'h9: sbox_inv = 4'h4;  4'hA: sbox_inv = 4'h6;  4'hB: sbox_inv = 4'h3;
      4'hC: sbox_inv = 4'h0;  4'hD: sbox_inv = 4'h7;  4'hE: sbox_inv = 4'h9;  4'hF: sbox_inv = 4'hA;
      default: sbox_inv = 4'h0;
    endcase
  endfunction

  function automatic logic [79:0] fwd_update(input logic [79:0] s, input logic [4:0] c);
    logic [79:0] r;
    r          = {s[18:0], s[79:19]};
    r[79:76]   = sbox(r[79:76]);
    r[19:15]   = r[19:15] ^ c;
    return r;
  endfunction

  function automatic logic [79:0] inv_update(input logic [79:0] s, input logic [4:0] c);
    logic [79:0] t;
    t          = s;
    t[19:15]   = t[19:15] ^ c;
    t[79:76]   = sbox_inv(t[79:76]);
    return {t[60:0], t[79:61]};
  endfunction

  // Next-state logic for the FSM, key state and round index.
  always_comb begin
    fsm_s   = fsm_r;
    state_s = state_r;
    idx_s   = idx_r;
    case (fsm_r)
      IDLE, DONE: begin
        if (bus.start) begin
          state_s = bus.key;
          idx_s   = 5'd0;
          fsm_s   = LOAD_FWD;
        end else begin
          fsm_s   = fsm_r;
        end
      end
      LOAD_FWD: begin
        state_s = fwd_update(state_r, idx_r + 5'd1);
        idx_s   = idx_r + 5'd1;
        if (idx_r == LAST_IDX - 5'd1) begin
          fsm_s = SERVE;
        end else begin
          fsm_s = LOAD_FWD;
        end
      end
      SERVE: begin
        if (bus.next) begin
          // Index 0 is the master key itself; consuming it ends the walk.
          if (idx_r == 5'd0) begin
            fsm_s = DONE;
          end else begin
            state_s = inv_update(state_r, idx_r);
            idx_s   = idx_r - 5'd1;
          end
        end else begin
          fsm_s = SERVE;
        end
      end
      default: fsm_s = IDLE;
    endcase
  end

  // State registers and registered status flags derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_r   <= IDLE;
      state_r <= 80'd0;
      idx_r   <= 5'd0;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      fsm_r   <= fsm_s;
      state_r <= state_s;
      idx_r   <= idx_s;
      busy_r  <= (fsm_s == LOAD_FWD) || (fsm_s == SERVE);
      valid_r <= (fsm_s == SERVE);
      done_r  <= (fsm_s == DONE);
    end
  end

  assign bus.roundkey  = state_r[79:16];
  assign bus.key_index = idx_r;
  assign bus.busy      = busy_r;
  assign bus.valid     = valid_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_present_inv_key_schedule.sv
// Directed and randomized checks of the inverse key schedule against a forward
// golden model, plus a PRESENT-80 decryption of the standard zero-key vector.
module tb_present_inv_key_schedule;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  present_inv_key_schedule_if bus();

  present_inv_key_schedule #(.ROUNDS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [3:0]  sb_tab [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                               4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  logic [63:0] gold [32];
  logic [63:0] ct = 64'h5579C1387B228445;
  logic [63:0] dec;
  int          exp_idx;

  typedef struct {
    logic [79:0] key;
    int          idx;
    logic [63:0] rk;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] model_step(input logic [79:0] s, input logic [4:0] c);
    logic [79:0] r;
    for (int b = 0; b < 80; b++) r[(b + 61) % 80] = s[b];
    r[79:76] = sb_tab[r[79:76]];
    r[19:15] = r[19:15] ^ c;
    return r;
  endfunction

  task automatic fill_gold(input logic [79:0] k);
    logic [79:0] s;
    s = k;
    gold[0] = s[79:16];
    for (int i = 1; i < 32; i++) begin
      s = model_step(s, 5'(i));
      gold[i] = s[79:16];
    end
  endtask

  function automatic logic [63:0] inv_player(input logic [63:0] s);
    logic [63:0] o;
    for (int i = 0; i < 63; i++) o[i] = s[(i * 16) % 63];
    o[63] = s[63];
    return o;
  endfunction

  function automatic logic [63:0] inv_slayer(input logic [63:0] s);
    logic [63:0] o;
    o = 64'd0;
    for (int n = 0; n < 16; n++)
      for (int x = 0; x < 16; x++)
        if (sb_tab[x] == s[n*4 +: 4]) o[n*4 +: 4] = 4'(x);
    return o;
  endfunction

  function automatic logic [79:0] rand80();
    return {16'($urandom), $urandom, $urandom};
  endfunction

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  bus.busy, 80'd0);
    check({tag, "_valid"}, bus.valid, 80'd0);
    check({tag, "_done"},  bus.done, 80'd0);
    check({tag, "_kidx"},  bus.key_index, 80'd0);
  endtask

  task automatic do_start(input logic [79:0] k);
    bus.key   = k;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.key   = rand80();  // later key changes must not matter
    check("start_busy", bus.busy, 80'd1);
    check("start_done", bus.done, 80'd0);
  endtask

  task automatic wait_valid(input bit noise);
    int n;
    n = 1;
    while (!bus.valid && n < 40) begin
      check("load_busy", bus.busy, 80'd1);
      if (noise) bus.start = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    check("valid_latency", 80'(n), 80'd32);
    exp_idx = 31;
  endtask

  // Consume keys down to stop_idx+1; returns with key stop_idx presented.
  task automatic serve_until(input int stop_idx, input bit rnd, input bit noise);
    int  guard;
    bit  nx;
    guard = 0;
    while (exp_idx > stop_idx && guard < 3000) begin
      guard++;
      check("serve_valid", bus.valid, 80'd1);
      check("serve_kidx", bus.key_index, 80'(exp_idx));
      check("serve_rk", bus.roundkey, gold[exp_idx]);
      nx = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.next = nx;
      if (noise) bus.start = 1'($urandom_range(0, 1));
      if (nx) begin
        if (exp_idx == 31) dec = ct ^ bus.roundkey;
        else dec = inv_slayer(inv_player(dec)) ^ bus.roundkey;
      end
      @(negedge clk);
      if (nx) exp_idx--;
    end
    bus.next  = 1'b0;
    bus.start = 1'b0;
    if (guard >= 3000) check("serve_timeout", 80'(exp_idx), 80'(stop_idx));
  endtask

  task automatic check_done();
    check("done_done",  bus.done, 80'd1);
    check("done_valid", bus.valid, 80'd0);
    check("done_busy",  bus.busy, 80'd0);
    check("done_rk",    bus.roundkey, gold[0]);
  endtask

  task automatic run_full(input logic [79:0] k, input bit rnd, input bit noise);
    fill_gold(k);
    do_start(k);
    wait_valid(noise);
    serve_until(-1, rnd, noise);
    check_done();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [79:0] k;
    vecs[0] = '{80'h0, 1, 64'hC000000000000000};
    vecs[1] = '{80'h0, 2, 64'h5000180000000001};
    vecs[2] = '{80'h0, 0, 64'h0000000000000000};
    vecs[3] = '{80'hFFFFFFFFFFFFFFFFFFFF, 0, 64'hFFFFFFFFFFFFFFFF};
    vecs[4] = '{80'h0123456789ABCDEF4567, 0, 64'h0123456789ABCDEF};

    rst = 1'b1; bus.start = 1'b0; bus.next = 1'b0; bus.key = 80'd0;
    @(negedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    check("reset_rk", bus.roundkey, 80'd0);
    rst = 1'b0;
    @(negedge clk);

    // Zero key, next held high, with decryption of the reference ciphertext.
    run_full(80'd0, 1'b0, 1'b0);
    check("decrypt_pt", dec, 80'd0);

    // Table vectors; vector 3 starts from DONE.
    for (int v = 0; v < 5; v++) begin
      fill_gold(vecs[v].key);
      do_start(vecs[v].key);
      wait_valid(1'b0);
      serve_until(vecs[v].idx, 1'b0, 1'b0);
      check($sformatf("vec%0d_kidx", v), bus.key_index, 80'(vecs[v].idx));
      check($sformatf("vec%0d_rk", v), bus.roundkey, vecs[v].rk);
      serve_until(-1, 1'b0, 1'b0);
      check_done();
    end

    for (int i = 0; i < 100; i++) run_full(rand80(), 1'b1, (i % 4) == 0);

    // Stall at index 17.
    k = rand80();
    fill_gold(k);
    do_start(k);
    wait_valid(1'b0);
    serve_until(17, 1'b0, 1'b0);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      check("stall_kidx", bus.key_index, 80'd17);
      check("stall_rk", bus.roundkey, gold[17]);
      check("stall_busy", bus.busy, 80'd1);
    end
    serve_until(-1, 1'b0, 1'b0);
    check_done();

    // Reset during LOAD_FWD at idx 10.
    do_start(rand80());
    repeat (10) @(negedge clk);
    pulse_reset();
    check_idle_outputs("rst_load");
    check("rst_load_rk", bus.roundkey, 80'd0);
    run_full(rand80(), 1'b0, 1'b0);

    // Reset during SERVE at key_index 5.
    k = rand80();
    fill_gold(k);
    do_start(k);
    wait_valid(1'b0);
    serve_until(5, 1'b0, 1'b0);
    pulse_reset();
    check_idle_outputs("rst_serve");
    run_full(rand80(), 1'b1, 1'b0);

    // Start from DONE with all-ones key.
    run_full(80'hFFFFFFFFFFFFFFFFFFFF, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
